mp_sequencer: RTL and testbench

Multi-cycle issue controller for the simple processor datapath. It accepts 32-bit instructions over a valid/ready handshake, decodes the opcode against the 11-entry valid set, and sequences register-file read, ALU operand capture and register-file write-back. It sits between the instruction source (testbench or fetch logic) and the reg-file/ALU pair, replacing ad-hoc opcode buffering with an explicit state machine.

---
 rtl/mp_pkg.sv | 56 +++++
 rtl/mp_opcode_check.sv | 21 ++
 rtl/mp_sequencer.sv | 135 +++++++++++++
 tb/tb_mp_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// mp_pkg: shared definitions for the multi-cycle issue controller.
//   - opcode encodings understood by the ALU
//   - bit positions of the instruction fields
//   - controller state encoding
//   - instruction field record and a helper that slices it out of a word
package mp_pkg;

    localparam int INSTR_W = 32;

    // ALU opcodes (the only encodings accepted by the controller)
    localparam logic [5:0] OP_MIN = 6'd2;
    localparam logic [5:0] OP_ABS = 6'd3;
    localparam logic [5:0] OP_ADD = 6'd4;
    localparam logic [5:0] OP_AVG = 6'd6;
    localparam logic [5:0] OP_MAX = 6'd7;
    localparam logic [5:0] OP_XOR = 6'd8;
    localparam logic [5:0] OP_SUB = 6'd10;
    localparam logic [5:0] OP_AND = 6'd11;
    localparam logic [5:0] OP_NEG = 6'd12;
    localparam logic [5:0] OP_NOT = 6'd13;
    localparam logic [5:0] OP_OR  = 6'd14;

    // Instruction field bit positions; bits [31:21] carry nothing.
    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 5;
    localparam int RS1_LSB = 6;
    localparam int RS1_MSB = 10;
    localparam int RS2_LSB = 11;
    localparam int RS2_MSB = 15;
    localparam int RD_LSB  = 16;
    localparam int RD_MSB  = 20;

    // Controller state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_EXEC  = 2'd2;
    localparam state_t ST_WRITE = 2'd3;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [5:0] opcode;
    } fields_t;

    function automatic fields_t decode_fields(input logic [20:0] low_bits);
        fields_t f;
        f.opcode = low_bits[OPC_MSB:OPC_LSB];
        f.rs1    = low_bits[RS1_MSB:RS1_LSB];
        f.rs2    = low_bits[RS2_MSB:RS2_LSB];
        f.rd     = low_bits[RD_MSB:RD_LSB];
        return f;
    endfunction

endpackage

// File: rtl/mp_opcode_check.sv
// mp_opcode_check: combinational opcode validity decode.
// Ports:
//   opcode  in  6  opcode field of the offered instruction
//   valid   out 1  high when opcode is one of the eleven ALU operations
module mp_opcode_check
    import mp_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       valid
);

    always_comb begin
        valid = 1'b0;
        case (opcode)
            OP_MIN, OP_ABS, OP_ADD, OP_AVG, OP_MAX, OP_XOR,
            OP_SUB, OP_AND, OP_NEG, OP_NOT, OP_OR: valid = 1'b1;
            default:                              valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mp_sequencer.sv
// mp_sequencer: multi-cycle issue controller between an instruction source
// and a register-file / ALU pair. One instruction is in flight at a time:
// IDLE (accept) -> READ (rf read strobe) -> EXEC (operand capture) ->
// WRITE (write-back + result pulse) -> IDLE.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid, in_ready, instr  instruction handshake and word
//   rf_re, rf_raddr1/2         reg-file read strobe and addresses
//   rf_rdata1/2                reg-file read data (one cycle after rf_re)
//   alu_opcode, alu_a, alu_b   registered ALU opcode and operands
//   alu_result                 combinational ALU result
//   rf_we, rf_waddr, rf_wdata  reg-file write-back (r0 writes suppressed)
//   res_valid, res_data        result pulse and held result value
//   op_err                     one-cycle pulse after an invalid opcode
//   busy                       controller not in IDLE
//   exec_count, err_count      saturating executed / rejected counters
module mp_sequencer
    import mp_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instr,
    output logic               rf_re,
    output logic [4:0]         rf_raddr1,
    output logic [4:0]         rf_raddr2,
    input  logic [31:0]        rf_rdata1,
    input  logic [31:0]        rf_rdata2,
    output logic [5:0]         alu_opcode,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    input  logic [31:0]        alu_result,
    output logic               rf_we,
    output logic [4:0]         rf_waddr,
    output logic [31:0]        rf_wdata,
    output logic               res_valid,
    output logic [31:0]        res_data,
    output logic               op_err,
    output logic               busy,
    output logic [COUNT_W-1:0] exec_count,
    output logic [COUNT_W-1:0] err_count
);

    // Handshake: a word transfers on a rising edge where in_valid and
    // in_ready are both high. in_ready depends only on state (high in IDLE),
    // never on in_valid; the source holds instr stable until the transfer.
    // in_valid while busy is simply not seen.

    state_t  state;
    fields_t fld;
    logic    opc_valid;
    logic    accept;
    logic    in_write;
    logic [31:0] res_hold;
    logic    unused_instr_hi;

    assign unused_instr_hi = ^instr[31:21];

    mp_opcode_check u_opcode_check (
        .opcode (instr[OPC_MSB:OPC_LSB]),
        .valid  (opc_valid)
    );

    assign accept   = (state == ST_IDLE) && in_valid;
    assign in_write = (state == ST_WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            fld        <= '0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            res_hold   <= '0;
            op_err     <= 1'b0;
            exec_count <= '0;
            err_count  <= '0;
        end else begin
            // Rejection costs only the accept cycle; the pulse lands in the
            // cycle after it while the controller is already free again.
            op_err <= accept && !opc_valid;

            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        fld <= decode_fields(instr[20:0]);
                        if (opc_valid) begin
                            state <= ST_READ;
                        end else if (err_count != '1) begin
                            err_count <= err_count + 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    alu_a      <= rf_rdata1;
                    alu_b      <= rf_rdata2;
                    alu_opcode <= fld.opcode;
                    state      <= ST_WRITE;
                end
                ST_WRITE: begin
                    res_hold <= alu_result;
                    if (exec_count != '1) begin
                        exec_count <= exec_count + 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rf_re     = (state == ST_READ);
    assign rf_raddr1 = fld.rs1;
    assign rf_raddr2 = fld.rs2;

    // Write-back is driven straight from the ALU during WRITE so the reg
    // file commits on the WRITE->IDLE edge, before any following READ.
    // An asynchronous reset inside WRITE drops rf_we before that edge.
    assign rf_we     = in_write && (fld.rd != 5'd0);
    assign rf_waddr  = fld.rd;
    assign rf_wdata  = in_write ? alu_result : 32'd0;
    assign res_valid = in_write;
    assign res_data  = in_write ? alu_result : res_hold;

endmodule

// File: tb/tb_mp_sequencer.sv
module tb_mp_sequencer;
    import mp_pkg::*;

    localparam int CW = 16;
    localparam int W  = 38;   // {we, waddr[4:0], data[31:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic          in_valid, in_ready;
    logic [31:0]   instr;
    logic          rf_re, rf_we;
    logic [4:0]    rf_raddr1, rf_raddr2, rf_waddr;
    logic [31:0]   rf_rdata1, rf_rdata2, rf_wdata;
    logic [5:0]    alu_opcode;
    logic [31:0]   alu_a, alu_b, alu_result;
    logic          res_valid, op_err, busy;
    logic [31:0]   res_data;
    logic [CW-1:0] exec_count, err_count;

    mp_sequencer #(.COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rf_re(rf_re), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .res_valid(res_valid), .res_data(res_data), .op_err(op_err),
        .busy(busy), .exec_count(exec_count), .err_count(err_count)
    );

    // ---------------- behavioural reg file ----------------
    logic [31:0] rf [32] = '{1: 32'd11930, 2: 32'd5348, 10: 32'd5630, default: 32'd0};

    always @(posedge clk) begin
        if (rf_re) begin
            rf_rdata1 <= (rf_raddr1 == 5'd0) ? 32'd0 : rf[rf_raddr1];
            rf_rdata2 <= (rf_raddr2 == 5'd0) ? 32'd0 : rf[rf_raddr2];
        end
        if (rf_we) rf[rf_waddr] <= rf_wdata;
    end

    // ---------------- behavioural ALU ----------------
    function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [32:0] s;
        s = $signed({a[31], a}) + $signed({b[31], b});
        case (op)
            OP_ADD: return a + b;
            OP_SUB: return a - b;
            OP_ABS: return a[31] ? (32'd0 - a) : a;
            OP_NEG: return 32'd0 - a;
            OP_MAX: return ($signed(a) > $signed(b)) ? a : b;
            OP_MIN: return ($signed(a) < $signed(b)) ? a : b;
            OP_AVG: return s[32:1];
            OP_NOT: return ~a;
            OP_OR:  return a | b;
            OP_AND: return a & b;
            OP_XOR: return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_opcode, alu_a, alu_b);

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    int res_pushed  = 0;
    int res_seen    = 0;
    int op_err_seen = 0;
    logic [W-1:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic we, input logic [4:0] waddr, input logic [31:0] data);
        exp_q.push_back({we, waddr, data});
        res_pushed++;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [4:0] rd);
        return {11'd0, rd, rs2, rs1, op};
    endfunction

    // Monitor: pops one expectation per result pulse.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            res_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_res_valid", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("res_data", res_data, mon_e[31:0]);
                check("rf_wdata", rf_wdata, mon_e[31:0]);
                check("rf_we", {31'd0, rf_we}, {31'd0, mon_e[37]});
                if (mon_e[37]) check("rf_waddr", {27'd0, rf_waddr}, {27'd0, mon_e[36:32]});
            end
        end
        if (rst_n && op_err) op_err_seen++;
        if (rf_we && !res_valid) check("stray_rf_we", 32'd1, 32'd0);
    end

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [31:0] ins, output int acc);
        int n;
        n = 0;
        instr    = ins;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            acc = -1;
        end else begin
            acc = cyc;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    logic [31:0] b_ins [12];
    logic [31:0] b_exp [12];
    logic [4:0]  b_rd  [12];
    int          b_acc [12];
    int a;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        instr    = 32'd0;
        idle_cycles(2);

        // Reset state
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rf_re", {31'd0, rf_re}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_exec_count", {16'd0, exec_count}, 32'd0);
        check("rst_err_count", {16'd0, err_count}, 32'd0);
        rst_n = 1'b1;
        idle_cycles(1);

        // add r0 + r10 -> r13
        push_exp(1'b1, 5'd13, 32'd5630);
        send(32'h000d5004, a);
        in_valid = 1'b0;
        check("read_rf_re", {31'd0, rf_re}, 32'd1);
        check("read_raddr1", {27'd0, rf_raddr1}, 32'd0);
        check("read_raddr2", {27'd0, rf_raddr2}, 32'd10);
        check("lat_c1_res_valid", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        check("lat_c2_res_valid", {31'd0, res_valid}, 32'd0);
        check("exec_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("lat_c3_res_valid", {31'd0, res_valid}, 32'd1);
        check("write_rf_we", {31'd0, rf_we}, 32'd1);
        check("write_waddr", {27'd0, rf_waddr}, 32'd13);
        @(negedge clk);
        check("add_exec_count", {16'd0, exec_count}, 32'd1);
        check("add_in_ready", {31'd0, in_ready}, 32'd1);
        check("add_res_hold", res_data, 32'd5630);
        check("add_r13", rf[13], 32'd5630);

        // opcode 0: invalid
        send(32'h00000000, a);
        in_valid = 1'b0;
        check("inv0_op_err", {31'd0, op_err}, 32'd1);
        check("inv0_rf_re", {31'd0, rf_re}, 32'd0);
        check("inv0_busy", {31'd0, busy}, 32'd0);
        check("inv0_err_count", {16'd0, err_count}, 32'd1);
        check("inv0_res_data", res_data, 32'd5630);
        @(negedge clk);
        check("inv0_op_err_pulse", {31'd0, op_err}, 32'd0);
        check("inv0_exec_count", {16'd0, exec_count}, 32'd1);

        // opcode 5 sits between valid encodings: invalid
        send(mk(6'd5, 5'd1, 5'd2, 5'd3), a);
        in_valid = 1'b0;
        check("inv5_op_err", {31'd0, op_err}, 32'd1);
        check("inv5_err_count", {16'd0, err_count}, 32'd2);
        @(negedge clk);

        // add r1 + r2 -> r1, then read r1 back through add r1 + r0 -> r3
        push_exp(1'b1, 5'd1, 32'd17278);
        send(32'h00011044, a);
        push_exp(1'b1, 5'd3, 32'd17278);
        send(mk(OP_ADD, 5'd1, 5'd0, 5'd3), a);
        in_valid = 1'b0;

        // add r2 + r10 -> r0: result reported, write suppressed
        push_exp(1'b0, 5'd0, 32'd10978);
        send(mk(OP_ADD, 5'd2, 5'd10, 5'd0), a);
        in_valid = 1'b0;
        idle_cycles(4);
        check("r1_after_add", rf[1], 32'd17278);
        check("r0_untouched", rf[0], 32'd0);

        // Back-to-back burst, in_valid held high throughout.
        // r1=17278 r2=5348 r10=5630
        b_ins[0]  = mk(OP_ADD, 5'd1,  5'd2,  5'd4);  b_exp[0]  = 32'd22626;     b_rd[0]  = 5'd4;
        b_ins[1]  = mk(OP_SUB, 5'd4,  5'd10, 5'd5);  b_exp[1]  = 32'd16996;     b_rd[1]  = 5'd5;
        b_ins[2]  = mk(OP_OR,  5'd2,  5'd10, 5'd6);  b_exp[2]  = 32'd5630;      b_rd[2]  = 5'd6;
        b_ins[3]  = mk(OP_AND, 5'd2,  5'd10, 5'd7);  b_exp[3]  = 32'd5348;      b_rd[3]  = 5'd7;
        b_ins[4]  = mk(OP_XOR, 5'd2,  5'd10, 5'd8);  b_exp[4]  = 32'd282;       b_rd[4]  = 5'd8;
        b_ins[5]  = mk(OP_MAX, 5'd1,  5'd2,  5'd9);  b_exp[5]  = 32'd17278;     b_rd[5]  = 5'd9;
        b_ins[6]  = mk(OP_MIN, 5'd1,  5'd2,  5'd11); b_exp[6]  = 32'd5348;      b_rd[6]  = 5'd11;
        b_ins[7]  = mk(OP_AVG, 5'd2,  5'd10, 5'd12); b_exp[7]  = 32'd5489;      b_rd[7]  = 5'd12;
        b_ins[8]  = mk(OP_NEG, 5'd8,  5'd0,  5'd14); b_exp[8]  = 32'hFFFFFEE6;  b_rd[8]  = 5'd14;
        b_ins[9]  = mk(OP_ABS, 5'd14, 5'd0,  5'd15); b_exp[9]  = 32'd282;       b_rd[9]  = 5'd15;
        b_ins[10] = mk(OP_NOT, 5'd0,  5'd0,  5'd16); b_exp[10] = 32'hFFFFFFFF;  b_rd[10] = 5'd16;
        b_ins[11] = mk(OP_SUB, 5'd5,  5'd8,  5'd17); b_exp[11] = 32'd16714;     b_rd[11] = 5'd17;
        for (int i = 0; i < 12; i++) begin
            push_exp(1'b1, b_rd[i], b_exp[i]);
            send(b_ins[i], b_acc[i]);
        end
        in_valid = 1'b0;
        for (int i = 1; i < 12; i++) begin
            check($sformatf("burst_spacing_%0d", i), b_acc[i] - b_acc[i-1], 32'd4);
        end
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        check("burst_drained", exp_q.size(), 32'd0);
        check("burst_r15", rf[15], 32'd282);
        check("burst_r17", rf[17], 32'd16714);
        check("burst_exec_count", {16'd0, exec_count}, 32'd16);
        check("burst_err_count", {16'd0, err_count}, 32'd2);

        // Reset asserted in the middle of WRITE: add r1 + r2 -> r18 aborted
        send(mk(OP_ADD, 5'd1, 5'd2, 5'd18), a);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("abort_rf_we", {31'd0, rf_we}, 32'd0);
        check("abort_res_valid", {31'd0, res_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_exec_count", {16'd0, exec_count}, 32'd0);
        check("abort_err_count", {16'd0, err_count}, 32'd0);
        check("abort_res_data", res_data, 32'd0);
        check("abort_alu_a", alu_a, 32'd0);
        check("abort_alu_opcode", {26'd0, alu_opcode}, 32'd0);
        check("abort_rf_waddr", {27'd0, rf_waddr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_r18", rf[18], 32'd0);

        // Recovery: add r10 + r0 -> r19
        push_exp(1'b1, 5'd19, 32'd5630);
        send(mk(OP_ADD, 5'd10, 5'd0, 5'd19), a);
        in_valid = 1'b0;
        idle_cycles(4);
        check("recover_exec_count", {16'd0, exec_count}, 32'd1);
        check("recover_r19", rf[19], 32'd5630);

        // Final accounting
        check("final_queue_empty", exp_q.size(), 32'd0);
        check("final_res_count", res_seen, res_pushed);
        check("final_op_err_count", op_err_seen, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
